// File: rtl/stv_sync_fifo_wm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stv_sync_fifo_wm_pkg : shared helpers for the watermark sync FIFO slice
// Rev 1.0
// ----------------------------------------------------------------------------
package stv_sync_fifo_wm_pkg;

  // Modulo-N successor; lets pointers wrap at non-power-of-2 depths.
  function automatic int wrap_next(input int value, input int modulus);
    return (value == modulus - 1) ? 0 : value + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stv_sync_fifo_wm_wrap_ctr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stv_wrap_ctr : modulo-N counter with synchronous clear and increment
// Rev 1.0
// ----------------------------------------------------------------------------
module stv_wrap_ctr
  import stv_sync_fifo_wm_pkg::*;
#(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] val_o
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = '0;
    end else if (inc_i) begin
      val_d = W'(wrap_next(int'(val_q), N));
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule
`default_nettype wire

// File: rtl/stv_sync_fifo_wm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stv_sync_fifo_wm : any-depth ready/valid FIFO with flush, watermarks and HWM
// Rev 1.0
// ----------------------------------------------------------------------------
module stv_sync_fifo_wm
  import stv_sync_fifo_wm_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int DEPTH       = 6,
  parameter  bit FLOWTHROUGH = 1'b0,
  localparam int PTRWIDTH    = $clog2(DEPTH),
  localparam int CNTWIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                flush,
  input  logic                wvalid,
  output logic                wready,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                rready,
  output logic                rvalid,
  output logic [WIDTH-1:0]    rdata,
  input  logic [CNTWIDTH-1:0] afull_thresh,
  input  logic [CNTWIDTH-1:0] aempty_thresh,
  output logic                empty,
  output logic                full,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [CNTWIDTH-1:0] count,
  output logic [CNTWIDTH-1:0] hwm
);

  localparam logic [CNTWIDTH-1:0] C_DEPTH_CNT = CNTWIDTH'(DEPTH);

  logic [PTRWIDTH-1:0] w_wptr;
  logic [PTRWIDTH-1:0] w_rptr;
  logic [CNTWIDTH-1:0] count_q;
  logic [CNTWIDTH-1:0] count_d;
  logic [CNTWIDTH-1:0] hwm_q;
  logic [CNTWIDTH-1:0] hwm_d;
  logic                w_writing;
  logic                w_reading;
  logic                w_ft_rd;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  if (DEPTH < 2) begin : g_depth_chk
    $fatal(1, "stv_sync_fifo_wm: DEPTH must be >= 2");
  end

  // Status comes only from the registered count, never from this cycle's handshake.
  assign empty        = (count_q == '0);
  assign full         = (count_q == C_DEPTH_CNT);
  assign almost_full  = (count_q >= afull_thresh);
  assign almost_empty = (count_q <= aempty_thresh);
  assign count        = count_q;
  assign hwm          = hwm_q;

  assign w_ft_rd   = FLOWTHROUGH && rready;
  assign wready    = !flush && (!full || w_ft_rd);
  assign rvalid    = !flush && (!empty || (FLOWTHROUGH && wvalid));
  assign w_reading = !flush && rready && !empty;
  // An empty flowthrough pass-through bypasses storage, so it is not a write.
  assign w_writing = !flush && wvalid && (w_ft_rd ? !empty : !full);

  if (FLOWTHROUGH) begin : g_ft
    assign rdata = empty ? wdata : mem_q[w_rptr];
  end else begin : g_no_ft
    assign rdata = mem_q[w_rptr];
  end

  stv_wrap_ctr #(.N(DEPTH), .W(PTRWIDTH)) u_wptr (
    .clk    (clk),
    .arst_n (arst_n),
    .clr_i  (flush),
    .inc_i  (w_writing),
    .val_o  (w_wptr)
  );

  stv_wrap_ctr #(.N(DEPTH), .W(PTRWIDTH)) u_rptr (
    .clk    (clk),
    .arst_n (arst_n),
    .clr_i  (flush),
    .inc_i  (w_reading),
    .val_o  (w_rptr)
  );

  always_comb begin
    count_d = count_q + CNTWIDTH'(w_writing) - CNTWIDTH'(w_reading);
    hwm_d   = (count_d > hwm_q) ? count_d : hwm_q;
    if (flush) begin
      count_d = '0;
      hwm_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= '0;
      hwm_q   <= '0;
    end else begin
      count_q <= count_d;
      hwm_q   <= hwm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_writing) begin
      mem_q[w_wptr] <= wdata;
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (!arst_n) count_q <= C_DEPTH_CNT)
    else $error("stv_sync_fifo_wm: count exceeds DEPTH");

endmodule
`default_nettype wire

// File: doc/stv_sync_fifo_wm.md
Name: stv_sync_fifo_wm

Overview:
Synchronous ready/valid FIFO with arbitrary depth, not limited to powers of 2. It is the next-generation generalisation of the team's basic sync FIFO, adding a synchronous flush, runtime-programmable almost-full and almost-empty watermarks, and a high-water-mark tracker for buffer sizing in debug. It sits between producer and consumer pipelines wherever flow control needs early back-pressure.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 6, number of entries; any integer >= 2.
- FLOWTHROUGH, 0, allows a same-cycle read/write when full or empty (combinational in-to-out paths).
- PTRWIDTH (localparam), $clog2(DEPTH), pointer width.
- CNTWIDTH (localparam), $clog2(DEPTH+1), width of count, threshold and high-water values.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents; highest priority.
- wvalid  in  1  write valid.
- wready  out  1  write ready.
- wdata  in  WIDTH  write data.
- rready  in  1  read ready.
- rvalid  out  1  read valid.
- rdata  out  WIDTH  read data.
- afull_thresh  in  CNTWIDTH  almost-full threshold.
- aempty_thresh  in  CNTWIDTH  almost-empty threshold.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= afull_thresh.
- almost_empty  out  1  count <= aempty_thresh.
- count  out  CNTWIDTH  current occupancy.
- hwm  out  CNTWIDTH  maximum occupancy since reset or flush.

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset state: wptr = rptr = count = hwm = 0, so empty=1, full=0, rvalid=0 (unless FLOWTHROUGH and wvalid), wready=1. Memory is not reset.
- State registers:
  - wptr and rptr, each PTRWIDTH bits, increment with explicit wrap: DEPTH-1 -> 0.
  - count register, updated each cycle as count + writing - reading.
  - empty, full, almost_* and count are all derived from the registered count only; none depend on this cycle's handshake.
- Handshake, without flush:
  - wready = !full || (FLOWTHROUGH && rready).
  - rvalid = !empty || (FLOWTHROUGH && wvalid).
  - reading = rready && !empty.
  - writing = wvalid && ((FLOWTHROUGH && rready) ? !empty : !full).
- FLOWTHROUGH, empty case: with rready=1, rdata = wdata in the same cycle; the word is not stored and count is unchanged.
- FLOWTHROUGH, full case: a simultaneous read and write is accepted; count stays DEPTH.
- Without FLOWTHROUGH:
  - read latency is 1 cycle from write to rvalid;
  - rdata = mem[rptr], valid only while rvalid=1.
- Simultaneous read and write when neither full nor empty: both pointers advance and count is unchanged.
- flush=1:
  - wready=0 and rvalid=0 that cycle; no handshake completes.
  - Next cycle: wptr = rptr = count = hwm = 0.
  - Memory contents are don't-care afterwards.
- Thresholds are sampled combinationally; software must hold them stable.
  - afull_thresh = 0 -> almost_full is always 1; afull_thresh > DEPTH -> never 1.
  - aempty_thresh >= DEPTH -> almost_empty is always 1.
- hwm register: hwm <= max(hwm, count_next) every cycle; it saturates at DEPTH.
- All arithmetic is unsigned at CNTWIDTH width; no overflow is possible because count <= DEPTH.
- Protocol violations by the environment (e.g. wvalid held while !wready) are back-pressure, not errors; data is never dropped.
- Simulation-only checks: fatal if DEPTH < 2; error if count > DEPTH.

Decomposition:
- No shared package typedefs are needed; the widths are local to the module.
- One sub-module, stv_wrap_ctr: a parametrised modulo-N counter with inc, clr and an async reset. It is instantiated twice, for wptr and rptr.

Test Plan:
1. DEPTH=6, FT=0: write 6 words 0x10..0x15 without reading -> full=1, count=6, wready=0, hwm=6; read 6 -> data 0x10..0x15 in order, empty=1.
2. DEPTH=6: 20 alternating write/read pairs with rptr near 5 -> pointers wrap 5->0, data in order, count stays within 0..1.
3. afull_thresh=4, aempty_thresh=1: fill one word per cycle -> almost_empty=1 at counts 0-1, almost_full rises at the cycle count reaches 4; thresholds 0 and 7 -> almost_full constant 1 and 0 respectively.
4. FT=1, empty, wvalid=rready=1, wdata=0xA5 -> rvalid=1, rdata=0xA5 same cycle, count stays 0; full FT with both asserted -> count stays 6, head word popped.
5. Fill 3 words, then flush with wvalid=rready=1 -> no handshake that cycle; next cycle count=0, hwm=0, empty=1; subsequent write/read returns the new data only.
6. Assert arst_n low mid-stream at count=4 -> outputs immediately at reset values (count=0, empty=1, hwm=0); after release, normal operation resumes.
